coalescing_write_buffer: RTL

- Parametrised next-generation posted write buffer that sits between the data cache write path and the main-memory arbiter.
- Queues byte-enabled word writes in a circular FIFO of configurable depth.
- Merges a new write into the youngest entry when their addresses match (coalescing).
- Drains entries to memory in order with an en/done handshake, and offers a combinational lookup port so cache read misses can forward pending store bytes.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/coalescing_write_buffer_if.sv | 44 ++++
 rtl/wb_fwd_merge.sv | 45 ++++
 rtl/coalescing_write_buffer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the coalescing posted-write buffer.
// Widths derived from DATAW/DEPTH are computed here so every file agrees on them.
package wb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } drain_state_e;

  function automatic int bew_of(input int dataw);
    return dataw / 8;
  endfunction

  function automatic int cw_of(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Single byte-lane merge: the new byte replaces the old one when its enable is set.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/coalescing_write_buffer_if.sv
// Cache-side write/lookup port and memory-side drain port of the write buffer.
// slave is the buffer's view; master is the view of whatever surrounds it.
interface coalescing_write_buffer_if #(
  parameter int ADRW  = 30,
  parameter int DATAW = 32,
  parameter int DEPTH = 4
);
  localparam int BEW = wb_pkg::bew_of(DATAW);
  localparam int CW  = wb_pkg::cw_of(DEPTH);

  logic             in_valid;
  logic             in_ready;
  logic [ADRW-1:0]  in_adr;
  logic [DATAW-1:0] in_data;
  logic [BEW-1:0]   in_byteen;

  logic [ADRW-1:0]  lk_adr;
  logic             lk_hit;
  logic [DATAW-1:0] lk_data;
  logic [BEW-1:0]   lk_byteen;

  logic             mem_en;
  logic [ADRW-1:0]  mem_adr;
  logic [DATAW-1:0] mem_data;
  logic [BEW-1:0]   mem_byteen;
  logic             mem_done;

  logic [CW-1:0]    count;
  logic             empty;
  logic             full;

  modport slave (
    input  in_valid, in_adr, in_data, in_byteen, lk_adr, mem_done,
    output in_ready, lk_hit, lk_data, lk_byteen,
    output mem_en, mem_adr, mem_data, mem_byteen, count, empty, full
  );

  modport master (
    output in_valid, in_adr, in_data, in_byteen, lk_adr, mem_done,
    input  in_ready, lk_hit, lk_data, lk_byteen,
    input  mem_en, mem_adr, mem_data, mem_byteen, count, empty, full
  );

endinterface

// File: rtl/wb_fwd_merge.sv
// Store-to-load forwarding network: walks entries oldest to youngest starting at
// the head pointer so the youngest matching entry owns each byte lane.
module wb_fwd_merge
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADRW  = 30,
  parameter int DATAW = 32
) (
  input  logic [ADRW-1:0]             i_lk_adr,
  input  logic [$clog2(DEPTH)-1:0]    i_head,
  input  logic [DEPTH-1:0]            i_vld,
  input  logic [DEPTH*ADRW-1:0]       i_adr_flat,
  input  logic [DEPTH*DATAW-1:0]      i_data_flat,
  input  logic [DEPTH*(DATAW/8)-1:0]  i_be_flat,
  output logic                        o_hit,
  output logic [DATAW-1:0]            o_data,
  output logic [DATAW/8-1:0]          o_be
);
  localparam int BEW = bew_of(DATAW);
  localparam int PW  = $clog2(DEPTH);

  logic [PW-1:0] w_idx;

  // NOTE: every output gets a default before the loop so no latch can be inferred.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    o_be   = '0;
    w_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = i_head + PW'(k);
      if (i_vld[w_idx] && (i_adr_flat[int'(w_idx)*ADRW +: ADRW] == i_lk_adr)) begin
        o_hit = 1'b1;
        for (int b = 0; b < BEW; b++) begin
          o_data[b*8 +: 8] = byte_merge(o_data[b*8 +: 8],
                                        i_data_flat[int'(w_idx)*DATAW + b*8 +: 8],
                                        i_be_flat[int'(w_idx)*BEW + b]);
        end
        o_be = o_be | i_be_flat[int'(w_idx)*BEW +: BEW];
      end
    end
  end

endmodule

// File: rtl/coalescing_write_buffer.sv
// Posted write buffer: circular FIFO of byte-enabled writes that coalesces into the
// youngest entry, drains in order over an en/done handshake and forwards pending bytes.
module coalescing_write_buffer
  import wb_pkg::*;
#(
  parameter int ADRW  = 30,
  parameter int DATAW = 32,
  parameter int DEPTH = 4
) (
  input logic                        clk,
  input logic                        reset,
  coalescing_write_buffer_if.slave   bus
);
  localparam int BEW = bew_of(DATAW);
  localparam int CW  = cw_of(DEPTH);
  localparam int PW  = $clog2(DEPTH);

  logic [ADRW-1:0]   r_adr  [DEPTH];
  logic [DATAW-1:0]  r_data [DEPTH];
  logic [BEW-1:0]    r_be   [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PW-1:0]     r_head, r_tail;
  logic [CW-1:0]     r_count;
  drain_state_e      r_state;
  logic              r_mem_en;
  logic [ADRW-1:0]   r_mem_adr;
  logic [DATAW-1:0]  r_mem_data;
  logic [BEW-1:0]    r_mem_be;

  logic [PW-1:0]     w_last;
  logic              w_full, w_empty, w_merge_ok, w_acc;
  logic              w_do_merge, w_do_alloc, w_pop, w_fwd_head;
  logic [DATAW-1:0]  w_mrg_data, w_launch_data;
  logic [BEW-1:0]    w_mrg_be, w_launch_be;
  logic [DEPTH*ADRW-1:0]  w_adr_flat;
  logic [DEPTH*DATAW-1:0] w_data_flat;
  logic [DEPTH*BEW-1:0]   w_be_flat;

  assign w_last     = r_tail - PW'(1);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  // The entry already handed to memory can no longer change, so it is never a merge target.
  assign w_merge_ok = !w_empty && (r_adr[w_last] == bus.in_adr)
                      && !((w_last == r_head) && (r_state == BUSY));
  assign bus.in_ready = !w_full || w_merge_ok;
  assign w_acc      = bus.in_valid && bus.in_ready && (bus.in_byteen != '0);
  assign w_do_merge = w_acc && w_merge_ok;
  assign w_do_alloc = w_acc && !w_merge_ok;
  assign w_pop      = (r_state == BUSY) && bus.mem_done;

  always_comb begin
    w_mrg_data = r_data[w_last];
    for (int b = 0; b < BEW; b++) begin
      w_mrg_data[b*8 +: 8] = byte_merge(r_data[w_last][b*8 +: 8], bus.in_data[b*8 +: 8],
                                        bus.in_byteen[b]);
    end
  end
  assign w_mrg_be = r_be[w_last] | bus.in_byteen;

  // A merge landing on the head in the same cycle it is launched must reach memory too.
  assign w_fwd_head    = w_do_merge && (w_last == r_head);
  assign w_launch_data = w_fwd_head ? w_mrg_data : r_data[r_head];
  assign w_launch_be   = w_fwd_head ? w_mrg_be   : r_be[r_head];

  // NOTE: payload storage has no reset; r_vld alone says which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_do_alloc) begin
      r_adr[r_tail]  <= bus.in_adr;
      r_data[r_tail] <= bus.in_data;
      r_be[r_tail]   <= bus.in_byteen;
    end else if (w_do_merge) begin
      r_data[w_last] <= w_mrg_data;
      r_be[w_last]   <= w_mrg_be;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld      <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_state    <= IDLE;
      r_mem_en   <= 1'b0;
      r_mem_adr  <= '0;
      r_mem_data <= '0;
      r_mem_be   <= '0;
    end else begin
      if (w_do_alloc) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
      end
      if (w_do_alloc && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_alloc && w_pop) r_count <= r_count - CW'(1);

      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_mem_en   <= 1'b1;
            r_mem_adr  <= r_adr[r_head];
            r_mem_data <= w_launch_data;
            r_mem_be   <= w_launch_be;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_done) begin
            r_mem_en <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign w_adr_flat[i*ADRW +: ADRW]    = r_adr[i];
    assign w_data_flat[i*DATAW +: DATAW] = r_data[i];
    assign w_be_flat[i*BEW +: BEW]       = r_be[i];
  end

  wb_fwd_merge #(.DEPTH(DEPTH), .ADRW(ADRW), .DATAW(DATAW)) u_fwd (
    .i_lk_adr   (bus.lk_adr),
    .i_head     (r_head),
    .i_vld      (r_vld),
    .i_adr_flat (w_adr_flat),
    .i_data_flat(w_data_flat),
    .i_be_flat  (w_be_flat),
    .o_hit      (bus.lk_hit),
    .o_data     (bus.lk_data),
    .o_be       (bus.lk_byteen)
  );

  assign bus.mem_en     = r_mem_en;
  assign bus.mem_adr    = r_mem_adr;
  assign bus.mem_data   = r_mem_data;
  assign bus.mem_byteen = r_mem_be;
  assign bus.count      = r_count;
  assign bus.empty      = w_empty;
  assign bus.full       = w_full;

endmodule
